// File: rtl/instruction_fetch_data.sv
// instruction_fetch_data: second I-cache fetch stage (IFD).
// It takes the IFT lookup result, does the hit compare, and reads the
// way-banked data array. On a miss it refills the line from memory. It then
// drives the tag update, cache_miss and resume_fetch handshake back to IFT.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   ift_valid/pc/tags/valid_bits   lookup result from IFT
//   wb_do_branch             redirect: drop this cycle's input
//   wb_icache_invalidate     whole-cache invalidate (with wb_do_branch)
//   cache_miss, resume_fetch one-cycle pulses to IFT
//   update_tag_en/set/tag    tag write port into IFT
//   mem_req/addr/ready       line read request handshake
//   mem_rvalid/rdata         refill data stream, word 0 first
//   ifd_valid/pc/instr       instruction to decode
module instruction_fetch_data #(
  parameter int unsigned NUM_WAYS   = 4,
  parameter int unsigned NUM_SETS   = 64,
  parameter int unsigned LINE_WORDS = 16,
  parameter int unsigned TAG_BITS   = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ift_valid,
  input  logic [31:0]                  ift_pc,
  input  logic [NUM_WAYS*TAG_BITS-1:0] ift_tags,
  input  logic [NUM_WAYS-1:0]          ift_valid_bits,
  input  logic                         wb_do_branch,
  input  logic                         wb_icache_invalidate,
  output logic                         cache_miss,
  output logic [NUM_WAYS-1:0]          update_tag_en,
  output logic [$clog2(NUM_SETS)-1:0]  update_tag_set,
  output logic [TAG_BITS-1:0]          update_tag,
  output logic                         resume_fetch,
  output logic                         mem_req,
  output logic [31:0]                  mem_addr,
  input  logic                         mem_ready,
  input  logic                         mem_rvalid,
  input  logic [31:0]                  mem_rdata,
  output logic                         ifd_valid,
  output logic [31:0]                  ifd_pc,
  output logic [31:0]                  ifd_instr
);

  localparam int unsigned WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int unsigned SET_W  = $clog2(NUM_SETS);
  localparam int unsigned WORD_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W  = WORD_W + 2;
  localparam int unsigned ADDR_W = WAY_W + SET_W + WORD_W;
  localparam int unsigned DEPTH  = NUM_WAYS * NUM_SETS * LINE_WORDS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM_REQ,
    S_REFILL,
    S_TAG_UPD,
    S_RESUME
  } state_t;

  state_t               r_state;
  logic [WAY_W-1:0]     r_rr;
  logic [WORD_W-1:0]    r_cnt;
  logic [WAY_W-1:0]     r_victim;
  logic [SET_W-1:0]     r_set;
  logic [TAG_BITS-1:0]  r_tag;
  logic                 r_inval_seen;
  logic                 r_cache_miss;
  logic [NUM_WAYS-1:0]  r_update_tag_en;
  logic [SET_W-1:0]     r_update_tag_set;
  logic [TAG_BITS-1:0]  r_update_tag;
  logic                 r_resume;
  logic                 r_mem_req;
  logic [31:0]          r_mem_addr;
  logic                 r_ifd_valid;
  logic [31:0]          r_ifd_pc;
  logic [31:0]          r_ifd_instr;
  logic [31:0]          r_data [DEPTH];

  logic [SET_W-1:0]     w_set;
  logic [WORD_W-1:0]    w_word;
  logic [TAG_BITS-1:0]  w_tag;
  logic [NUM_WAYS-1:0]  w_hit_way;
  logic                 w_hit;
  logic [WAY_W-1:0]     w_hit_idx;
  logic [WAY_W-1:0]     w_victim;
  logic                 w_all_valid;
  logic [WAY_W-1:0]     w_rr_next;
  logic [NUM_WAYS-1:0]  w_victim_oh;
  logic                 w_last;
  logic [ADDR_W-1:0]    w_rd_addr;
  logic [ADDR_W-1:0]    w_wr_addr;
  logic [31:0]          w_rd_data;
  logic                 w_unused;

  assign w_set    = ift_pc[OFF_W +: SET_W];
  assign w_word   = ift_pc[2 +: WORD_W];
  assign w_tag    = ift_pc[31 -: TAG_BITS];
  assign w_unused = ^ift_pc[1:0];

  // Per-way tag compare; at most one way may match.
  always_comb begin
    w_hit_way = '0;
    w_hit_idx = '0;
    for (int w = 0; w < int'(NUM_WAYS); w++) begin
      w_hit_way[w] = ift_valid_bits[w] && (ift_tags[w*TAG_BITS +: TAG_BITS] == w_tag);
      if (w_hit_way[w]) w_hit_idx = WAY_W'(w);
    end
  end
  assign w_hit = |w_hit_way;

  // Victim: lowest invalid way, else the round-robin pointer.
  always_comb begin
    w_victim = r_rr;
    for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
      if (!ift_valid_bits[w]) w_victim = WAY_W'(w);
    end
  end
  assign w_all_valid = &ift_valid_bits;
  assign w_rr_next   = (r_rr == WAY_W'(NUM_WAYS - 1)) ? '0 : r_rr + WAY_W'(1);

  assign w_victim_oh = {{(NUM_WAYS-1){1'b0}}, 1'b1} << r_victim;
  assign w_last      = (r_cnt == WORD_W'(LINE_WORDS - 1));

  // Data array, flattened as {way, set, word}; not reset.
  assign w_rd_addr = {w_hit_idx, w_set, w_word};
  assign w_wr_addr = {r_victim, r_set, r_cnt};
  assign w_rd_data = r_data[w_rd_addr];

  always_ff @(posedge clk) begin
    if (rst && (r_state == S_REFILL) && mem_rvalid) begin
      r_data[w_wr_addr] <= mem_rdata;
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state          <= S_IDLE;
      r_rr             <= '0;
      r_cnt            <= '0;
      r_victim         <= '0;
      r_set            <= '0;
      r_tag            <= '0;
      r_inval_seen     <= 1'b0;
      r_cache_miss     <= 1'b0;
      r_update_tag_en  <= '0;
      r_update_tag_set <= '0;
      r_update_tag     <= '0;
      r_resume         <= 1'b0;
      r_mem_req        <= 1'b0;
      r_mem_addr       <= '0;
      r_ifd_valid      <= 1'b0;
      r_ifd_pc         <= '0;
      r_ifd_instr      <= '0;
    end else begin
      r_cache_miss    <= 1'b0;
      r_ifd_valid     <= 1'b0;
      r_resume        <= 1'b0;
      r_update_tag_en <= '0;
      case (r_state)
        S_IDLE: begin
          if (ift_valid && !wb_do_branch) begin
            if (w_hit) begin
              r_ifd_valid <= 1'b1;
              r_ifd_pc    <= ift_pc;
              r_ifd_instr <= w_rd_data;
            end else begin
              r_cache_miss <= 1'b1;
              r_mem_req    <= 1'b1;
              r_mem_addr   <= {ift_pc[31:OFF_W], OFF_W'(0)};
              r_set        <= w_set;
              r_tag        <= w_tag;
              r_victim     <= w_victim;
              r_cnt        <= '0;
              r_inval_seen <= 1'b0;
              if (w_all_valid) r_rr <= w_rr_next;
              r_state      <= S_MEM_REQ;
            end
          end
        end
        S_MEM_REQ: begin
          if (wb_icache_invalidate) r_inval_seen <= 1'b1;
          if (mem_ready) begin
            r_mem_req <= 1'b0;
            r_state   <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (wb_icache_invalidate) r_inval_seen <= 1'b1;
          if (mem_rvalid) begin
            r_cnt <= r_cnt + WORD_W'(1);
            if (w_last) begin
              r_cnt            <= '0;
              r_update_tag_en  <= (r_inval_seen || wb_icache_invalidate) ? '0 : w_victim_oh;
              r_update_tag_set <= r_set;
              r_update_tag     <= r_tag;
              r_state          <= S_TAG_UPD;
            end
          end
        end
        S_TAG_UPD: begin
          r_resume <= 1'b1;
          r_state  <= S_RESUME;
        end
        S_RESUME: begin
          r_inval_seen <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cache_miss     = r_cache_miss;
  // An invalidate arriving in the tag-update cycle itself still cancels it.
  assign update_tag_en  = r_update_tag_en & ~{NUM_WAYS{wb_icache_invalidate}};
  assign update_tag_set = r_update_tag_set;
  assign update_tag     = r_update_tag;
  assign resume_fetch   = r_resume;
  assign mem_req        = r_mem_req;
  assign mem_addr       = r_mem_addr;
  assign ifd_valid      = r_ifd_valid;
  assign ifd_pc         = r_ifd_pc;
  assign ifd_instr      = r_ifd_instr;

endmodule
